// File: rtl/rv32i_decoder_glue_pkg.sv
// rv32i_decoder_glue_pkg: opcode constants, ImmSrc/wb_sel/ALUOp encodings and the decoded-control record.
package rv32i_decoder_glue_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       illegal;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/rv32i_decoder_glue_if.sv
// rv32i_decoder_glue_if: instruction word in, decoded fields and controls out.
interface rv32i_decoder_glue_if;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        regWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc;
    logic        BranchSig;
    logic        Branch;
    logic        Jump;
    logic        JAL;
    logic        JALR;
    logic [1:0]  ALUOp;
    logic [2:0]  ImmSrc;
    logic [1:0]  wb_sel;
    logic        illegal_q;

    modport master (
        output instr,
        input  rd, rs1, rs2, imm, regWrite, MemRead, MemWrite, ALUSrc, BranchSig, Branch,
               Jump, JAL, JALR, ALUOp, ImmSrc, wb_sel, illegal_q
    );

    modport slave (
        input  instr,
        output rd, rs1, rs2, imm, regWrite, MemRead, MemWrite, ALUSrc, BranchSig, Branch,
               Jump, JAL, JALR, ALUOp, ImmSrc, wb_sel, illegal_q
    );
endinterface

// File: rtl/rv32i_decoder_glue_imm_gen.sv
// rv32i_decoder_glue_imm_gen: sign-extended immediate for the I/S/B/U/J formats, zero otherwise.
module rv32i_decoder_glue_imm_gen
    import rv32i_decoder_glue_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [2:0]  imm_src,
    output logic [31:0] imm
);
    always_comb begin
        imm = imm_src == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
              imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              imm_src == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
              imm_src == IMM_U ? {instr[31:12], 12'b0} :
              imm_src == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
              32'b0;
    end
endmodule

// File: rtl/rv32i_decoder_glue.sv
// rv32i_decoder_glue: combinational RV32I decode front end with a registered illegal-opcode flag.
module rv32i_decoder_glue
    import rv32i_decoder_glue_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    rv32i_decoder_glue_if.slave bus
);
    ctrl_t ctrl;

    always_comb begin
        ctrl         = '0;
        ctrl.imm_src = IMM_NONE;
        case (bus.instr[6:0])
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.imm_src   = IMM_I;
            end
            OP_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.wb_sel    = WB_MEM;
                ctrl.imm_src   = IMM_I;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.imm_src   = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_BR;
                ctrl.imm_src = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.jal       = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.imm_src   = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.wb_sel    = WB_PC4;
                ctrl.imm_src   = IMM_I;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_PASSB;
                ctrl.imm_src   = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = IMM_U;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign bus.rd        = bus.instr[11:7];
    assign bus.rs1       = bus.instr[19:15];
    assign bus.rs2       = bus.instr[24:20];
    assign bus.regWrite  = ctrl.reg_write;
    assign bus.MemRead   = ctrl.mem_read;
    assign bus.MemWrite  = ctrl.mem_write;
    assign bus.ALUSrc    = ctrl.alu_src;
    assign bus.BranchSig = ctrl.branch;
    assign bus.Branch    = ctrl.branch;
    assign bus.Jump      = ctrl.jal | ctrl.jalr;
    assign bus.JAL       = ctrl.jal;
    assign bus.JALR      = ctrl.jalr;
    assign bus.ALUOp     = ctrl.alu_op;
    assign bus.ImmSrc    = ctrl.imm_src;
    assign bus.wb_sel    = ctrl.wb_sel;

    rv32i_decoder_glue_imm_gen u_imm_gen (
        .instr   (bus.instr[31:7]),
        .imm_src (ctrl.imm_src),
        .imm     (bus.imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.illegal_q <= 1'b0;
        else        bus.illegal_q <= ctrl.illegal;
    end
endmodule

// File: tb/tb_rv32i_decoder_glue.sv
// tb_rv32i_decoder_glue: table-driven decode vectors through a scoreboard queue, plus illegal/reset sequences.
module tb_rv32i_decoder_glue;
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [15:0] ctl;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[15];
    vec_t sbq[$];

    rv32i_decoder_glue_if bus ();

    rv32i_decoder_glue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ctl(input bit rw, mr, mw, as, br, j, jal, jalr,
                                        input bit [1:0] aop, input bit [2:0] isrc, input bit [1:0] wb);
        return {rw, mr, mw, as, br, br, j, jal, jalr, aop, isrc, wb};
    endfunction

    function automatic logic [15:0] dut_ctl();
        return {bus.regWrite, bus.MemRead, bus.MemWrite, bus.ALUSrc, bus.BranchSig, bus.Branch,
                bus.Jump, bus.JAL, bus.JALR, bus.ALUOp, bus.ImmSrc, bus.wb_sel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        vecs[0]  = '{32'h002082B3, 5'd5,  5'd1,  5'd2,  32'h00000000, ctl(1,0,0,0,0,0,0,0,2'b10,3'b111,2'd0), 1'b0};
        vecs[1]  = '{32'h07F08313, 5'd6,  5'd1,  5'd31, 32'h0000007F, ctl(1,0,0,1,0,0,0,0,2'b10,3'b000,2'd0), 1'b0};
        vecs[2]  = '{32'h0181A383, 5'd7,  5'd3,  5'd24, 32'h00000018, ctl(1,1,0,1,0,0,0,0,2'b00,3'b000,2'd1), 1'b0};
        vecs[3]  = '{32'h00822E23, 5'd28, 5'd4,  5'd8,  32'h0000001C, ctl(0,0,1,1,0,0,0,0,2'b00,3'b001,2'd0), 1'b0};
        vecs[4]  = '{32'h00208863, 5'd16, 5'd1,  5'd2,  32'h00000010, ctl(0,0,0,0,1,0,0,0,2'b01,3'b010,2'd0), 1'b0};
        vecs[5]  = '{32'h0000007F, 5'd0,  5'd0,  5'd0,  32'h00000000, ctl(0,0,0,0,0,0,0,0,2'b00,3'b111,2'd0), 1'b1};
        vecs[6]  = '{32'h020000EF, 5'd1,  5'd0,  5'd0,  32'h00000020, ctl(1,0,0,1,0,1,1,0,2'b00,3'b100,2'd2), 1'b0};
        vecs[7]  = '{32'h014482E7, 5'd5,  5'd9,  5'd20, 32'h00000014, ctl(1,0,0,1,0,1,0,1,2'b00,3'b000,2'd2), 1'b0};
        vecs[8]  = '{32'h12345537, 5'd10, 5'd8,  5'd3,  32'h12345000, ctl(1,0,0,1,0,0,0,0,2'b11,3'b011,2'd0), 1'b0};
        vecs[9]  = '{32'h01234597, 5'd11, 5'd6,  5'd18, 32'h01234000, ctl(1,0,0,1,0,0,0,0,2'b00,3'b011,2'd0), 1'b0};
        vecs[10] = '{32'hFFF00093, 5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, ctl(1,0,0,1,0,0,0,0,2'b10,3'b000,2'd0), 1'b0};
        vecs[11] = '{32'hFE000EE3, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, ctl(0,0,0,0,1,0,0,0,2'b01,3'b010,2'd0), 1'b0};
        vecs[12] = '{32'hFF9FF06F, 5'd0,  5'd31, 5'd25, 32'hFFFFFFF8, ctl(1,0,0,1,0,1,1,0,2'b00,3'b100,2'd2), 1'b0};
        vecs[13] = '{32'h00000000, 5'd0,  5'd0,  5'd0,  32'h00000000, ctl(0,0,0,0,0,0,0,0,2'b00,3'b111,2'd0), 1'b1};
        vecs[14] = '{32'h002082B3, 5'd5,  5'd1,  5'd2,  32'h00000000, ctl(1,0,0,0,0,0,0,0,2'b10,3'b111,2'd0), 1'b0};

        // Reset held across clock edges with an illegal opcode present.
        bus.instr = 32'h0000007F;
        repeat (2) @(posedge clk);
        #1 check("reset_illegal_q", {31'b0, bus.illegal_q}, 32'h0);
        check("reset_ctl_unaffected", {16'b0, dut_ctl()}, {16'b0, ctl(0,0,0,0,0,0,0,0,2'b00,3'b111,2'd0)});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.instr = vecs[i].instr;
            sbq.push_back(vecs[i]);
            #1;
            e = sbq.pop_front();
            check($sformatf("v%0d_rd", i),  {27'b0, bus.rd},  {27'b0, e.rd});
            check($sformatf("v%0d_rs1", i), {27'b0, bus.rs1}, {27'b0, e.rs1});
            check($sformatf("v%0d_rs2", i), {27'b0, bus.rs2}, {27'b0, e.rs2});
            check($sformatf("v%0d_imm", i), bus.imm, e.imm);
            check($sformatf("v%0d_ctl", i), {16'b0, dut_ctl()}, {16'b0, e.ctl});
            @(posedge clk);
            #1 check($sformatf("v%0d_illegal_q", i), {31'b0, bus.illegal_q}, {31'b0, e.ill});
        end

        // Illegal opcode latched, then cleared asynchronously between clock edges.
        @(negedge clk);
        bus.instr = 32'h0000007F;
        @(posedge clk);
        #1 check("seq_illegal_set", {31'b0, bus.illegal_q}, 32'h1);
        #1 rst_n = 1'b0;
        #1 check("seq_async_clear", {31'b0, bus.illegal_q}, 32'h0);
        check("seq_ctl_in_reset", {16'b0, dut_ctl()}, {16'b0, ctl(0,0,0,0,0,0,0,0,2'b00,3'b111,2'd0)});
        bus.instr = 32'h0181A383;
        #1 check("seq_lw_imm_in_reset", bus.imm, 32'h00000018);
        check("seq_lw_ctl_in_reset", {16'b0, dut_ctl()}, {16'b0, ctl(1,1,0,1,0,0,0,0,2'b00,3'b000,2'd1)});
        @(negedge clk);
        rst_n = 1'b1;
        bus.instr = 32'h0000007F;
        @(posedge clk);
        #1 check("seq_relatch", {31'b0, bus.illegal_q}, 32'h1);
        @(negedge clk);
        bus.instr = 32'h12345537;
        @(posedge clk);
        #1 check("seq_clear_by_legal", {31'b0, bus.illegal_q}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
